// File: rtl/pipe_pkg.sv
// pipe_pkg: shared encodings, bundle layouts and nop patterns for the
// Y86-64 pipeline register bank.
//   STAT_*      : 2-bit instruction status codes
//   I_NOP       : nop instruction code
//   RNONE       : "no register" id
//   *_bundle_t  : packed stage bundles; D_W/E_W/M_W/W_W are their widths
//   *_NOP       : bubble/reset patterns; CC_RESET: {ZF,SF,OF} after reset
package pipe_pkg;

  localparam int WORD_W = 64;

  localparam logic [1:0] STAT_AOK = 2'd0;
  localparam logic [1:0] STAT_HLT = 2'd1;
  localparam logic [1:0] STAT_ADR = 2'd2;
  localparam logic [1:0] STAT_INS = 2'd3;

  localparam logic [3:0] I_NOP = 4'h1;
  localparam logic [3:0] RNONE = 4'hF;

  typedef struct packed {
    logic [1:0]        stat;
    logic [3:0]        icode;
    logic [3:0]        ifun;
    logic [3:0]        rA;
    logic [3:0]        rB;
    logic [WORD_W-1:0] valC;
    logic [WORD_W-1:0] valP;
  } d_bundle_t;

  typedef struct packed {
    logic [1:0]        stat;
    logic [3:0]        icode;
    logic [3:0]        ifun;
    logic [WORD_W-1:0] valC;
    logic [WORD_W-1:0] valA;
    logic [WORD_W-1:0] valB;
    logic [3:0]        dstE;
    logic [3:0]        dstM;
    logic [3:0]        srcA;
    logic [3:0]        srcB;
  } e_bundle_t;

  typedef struct packed {
    logic [1:0]        stat;
    logic [3:0]        icode;
    logic              Cnd;
    logic [WORD_W-1:0] valE;
    logic [WORD_W-1:0] valA;
    logic [3:0]        dstE;
    logic [3:0]        dstM;
  } m_bundle_t;

  typedef struct packed {
    logic [1:0]        stat;
    logic [3:0]        icode;
    logic [WORD_W-1:0] valE;
    logic [WORD_W-1:0] valM;
    logic [3:0]        dstE;
    logic [3:0]        dstM;
  } w_bundle_t;

  localparam int D_W = $bits(d_bundle_t);
  localparam int E_W = $bits(e_bundle_t);
  localparam int M_W = $bits(m_bundle_t);
  localparam int W_W = $bits(w_bundle_t);

  localparam d_bundle_t D_NOP = '{stat: STAT_AOK, icode: I_NOP, ifun: 4'h0,
                                  rA: RNONE, rB: RNONE, valC: '0, valP: '0};
  localparam e_bundle_t E_NOP = '{stat: STAT_AOK, icode: I_NOP, ifun: 4'h0,
                                  valC: '0, valA: '0, valB: '0,
                                  dstE: RNONE, dstM: RNONE,
                                  srcA: RNONE, srcB: RNONE};
  localparam m_bundle_t M_NOP = '{stat: STAT_AOK, icode: I_NOP, Cnd: 1'b0,
                                  valE: '0, valA: '0,
                                  dstE: RNONE, dstM: RNONE};
  localparam w_bundle_t W_NOP = '{stat: STAT_AOK, icode: I_NOP,
                                  valE: '0, valM: '0,
                                  dstE: RNONE, dstM: RNONE};

  localparam logic [2:0] CC_RESET = 3'b100;

endpackage

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: one pipeline register with reset > stall > bubble > load
// priority. Reset and bubble both load NOP.
//   clk, rst : clock, synchronous active-high reset
//   stall    : hold current contents
//   bubble   : load NOP
//   din/dout : next-stage bundle in, registered bundle out
module pipe_stage_reg #(
  parameter int               WIDTH = 1,
  parameter logic [WIDTH-1:0] NOP   = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             bubble,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] dout_d;
  logic [WIDTH-1:0] dout_q;

  always_comb begin
    dout_d = din;
    if (stall) begin
      dout_d = dout_q;
    end else if (bubble) begin
      dout_d = NOP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q <= NOP;
    end else begin
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/pipe_stage_bank.sv
// pipe_stage_bank: F/D/E/M/W pipeline registers plus condition codes,
// applying the hazard-control strobes at each rising edge.
//   clk, rst            : clock, synchronous active-high reset
//   F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc : strobes
//   f_predPC / F_predPC : predicted PC in / registered
//   d_in..w_in / D_out..W_out : stage bundles in / registered
//   cc_in / cc          : {ZF,SF,OF} in / registered
//   ctl_err             : sticky, set when D_stall and D_bubble coincide
// Optional (PIPE_PERF_CNT_EN): stall_cnt counts D_stall edges, bubble_cnt
// counts E_bubble edges; both saturate and clear on rst.
module pipe_stage_bank
  import pipe_pkg::*;
#(
  parameter int WORD = WORD_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            F_stall,
  input  logic            D_stall,
  input  logic            D_bubble,
  input  logic            E_bubble,
  input  logic            M_bubble,
  input  logic            W_stall,
  input  logic            set_cc,
  input  logic [WORD-1:0] f_predPC,
  output logic [WORD-1:0] F_predPC,
  input  d_bundle_t       d_in,
  output d_bundle_t       D_out,
  input  e_bundle_t       e_in,
  output e_bundle_t       E_out,
  input  m_bundle_t       m_in,
  output m_bundle_t       M_out,
  input  w_bundle_t       w_in,
  output w_bundle_t       W_out,
  input  logic [2:0]      cc_in,
  output logic [2:0]      cc,
`ifdef PIPE_PERF_CNT_EN
  output logic [31:0]     stall_cnt,
  output logic [31:0]     bubble_cnt,
`endif
  output logic            ctl_err
);

  pipe_stage_reg #(.WIDTH(WORD), .NOP('0)) u_f (
    .clk(clk), .rst(rst), .stall(F_stall), .bubble(1'b0),
    .din(f_predPC), .dout(F_predPC)
  );

  // Stall has priority over bubble, so an illegal D_stall+D_bubble holds D.
  pipe_stage_reg #(.WIDTH(D_W), .NOP(D_NOP)) u_d (
    .clk(clk), .rst(rst), .stall(D_stall), .bubble(D_bubble),
    .din(d_in), .dout(D_out)
  );

  pipe_stage_reg #(.WIDTH(E_W), .NOP(E_NOP)) u_e (
    .clk(clk), .rst(rst), .stall(1'b0), .bubble(E_bubble),
    .din(e_in), .dout(E_out)
  );

  pipe_stage_reg #(.WIDTH(M_W), .NOP(M_NOP)) u_m (
    .clk(clk), .rst(rst), .stall(1'b0), .bubble(M_bubble),
    .din(m_in), .dout(M_out)
  );

  pipe_stage_reg #(.WIDTH(W_W), .NOP(W_NOP)) u_w (
    .clk(clk), .rst(rst), .stall(W_stall), .bubble(1'b0),
    .din(w_in), .dout(W_out)
  );

  logic [2:0] cc_d, cc_q;
  logic       ctl_err_d, ctl_err_q;

  always_comb begin
    cc_d      = set_cc ? cc_in : cc_q;
    ctl_err_d = ctl_err_q | (D_stall & D_bubble);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cc_q      <= CC_RESET;
      ctl_err_q <= 1'b0;
    end else begin
      cc_q      <= cc_d;
      ctl_err_q <= ctl_err_d;
    end
  end

  assign cc      = cc_q;
  assign ctl_err = ctl_err_q;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cnt_d, stall_cnt_q;
  logic [31:0] bubble_cnt_d, bubble_cnt_q;

  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (D_stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (E_bubble && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
      bubble_cnt_d = bubble_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: doc/pipe_stage_bank.md
Name: pipe_stage_bank

Overview:
- Holds the F, D, E, M and W pipeline registers and the condition-code register of the Y86-64 pipelined core.
- It is the consumer side of the hazard-control interface. It takes the stall, bubble and set_cc strobes from the pipeline control unit and applies them at each clock edge.
- Stage logic drives the *_in bundles; registered bundles feed the next stage.

Parameters:
- WORD, 64, data word width (valC, valP, valA, valB, valE, valM, predPC).

Ports:
- clk  in  1  core clock; every register updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- F_stall  in  1  hold F_predPC.
- D_stall  in  1  hold the D register.
- D_bubble  in  1  load the D nop pattern.
- E_bubble  in  1  load the E nop pattern.
- M_bubble  in  1  load the M nop pattern.
- W_stall  in  1  hold the W register.
- set_cc  in  1  load cc from cc_in.
- f_predPC  in  WORD  next predicted PC.
- F_predPC  out  WORD  registered predicted PC.
- d_in  in  D_W  fetch-stage bundle: stat, icode, ifun, rA, rB, valC, valP.
- D_out  out  D_W  registered D bundle.
- e_in  in  E_W  decode-stage bundle: stat, icode, ifun, valC, valA, valB, dstE, dstM, srcA, srcB.
- E_out  out  E_W  registered E bundle.
- m_in  in  M_W  execute-stage bundle: stat, icode, Cnd, valE, valA, dstE, dstM.
- M_out  out  M_W  registered M bundle.
- w_in  in  W_W  memory-stage bundle: stat, icode, valE, valM, dstE, dstM.
- W_out  out  W_W  registered W bundle.
- cc_in  in  3  {ZF, SF, OF} computed in execute.
- cc  out  3  registered condition codes.
- ctl_err  out  1  sticky flag: illegal control combination seen.

Behaviour:
- Encodings:
  - stat: AOK=0, HLT=1, ADR=2, INS=3.
  - icode NOP=4'h1.
  - Register id RNONE=4'hF.
- Nop patterns:
  - D: stat=AOK, icode=NOP, ifun=0, rA=rB=RNONE, valC=valP=0.
  - E: stat=AOK, icode=NOP, ifun=0, vals=0, dstE=dstM=srcA=srcB=RNONE.
  - M: stat=AOK, icode=NOP, Cnd=0, vals=0, dstE=dstM=RNONE.
  - W (reset only): stat=AOK, icode=NOP, vals=0, dstE=dstM=RNONE.
- Reset (rst=1 at edge):
  - F_predPC=0.
  - D/E/M/W load their nop patterns.
  - cc=3'b100 (ZF=1, SF=0, OF=0).
  - ctl_err=0.
  - Reset overrides all strobes.
- Per edge, per register, with priority order:
  1. rst.
  2. stall: hold.
  3. bubble: load nop.
  4. otherwise: load the *_in bundle.
- Latency: one cycle from *_in to the registered output. There is no bypass.
- F: F_stall=1 holds; otherwise F_predPC<=f_predPC.
- D: D_stall and D_bubble both 1 → hold wins and ctl_err<=1.
- E: E_bubble=1 loads the nop pattern; otherwise E_out<=e_in.
- M: M_bubble=1 loads the nop pattern; otherwise M_out<=m_in.
- W: W_stall=1 holds; otherwise W_out<=w_in. W has no bubble input.
- CC: set_cc=1 → cc<=cc_in; otherwise hold. set_cc is independent of the stage stalls.
- ctl_err:
  - Set when D_stall and D_bubble are both 1 at an edge.
  - Remains 1 until rst.
  - Never affects data.
- All strobes are sampled only at the edge; no output is combinational from an input.

Optional Feature:
- Macro: PIPE_PERF_CNT_EN.
- When defined:
  - Adds outputs stall_cnt[31:0] and bubble_cnt[31:0].
  - stall_cnt increments on each edge where D_stall=1.
  - bubble_cnt increments on each edge where E_bubble=1.
  - Both counters saturate at 32'hFFFFFFFF.
  - Both clear on rst.
- When undefined: these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Package pipe_pkg holds:
  - Stat and icode constants, RNONE.
  - Packed struct typedefs d_bundle_t, e_bundle_t, m_bundle_t, w_bundle_t; D_W/E_W/M_W/W_W are their $bits.
  - Nop-pattern constants D_NOP, E_NOP, M_NOP, W_NOP.
  - CC_RESET=3'b100.
- Sub-module pipe_stage_reg(WIDTH, NOP):
  - Inputs: clk, rst, stall, bubble, din. Output: dout.
  - Implements priority order 1-4.
  - Instantiated once each for F, D, E, M and W. Unused strobes are tied to 0.
  - F instance uses NOP=0.

Test Plan:
- Reset: assert rst one cycle with random *_in → F_predPC=0, D/E/M/W equal their NOP patterns, cc=3'b100, ctl_err=0.
- Load-use hazard: d_in icode=4'h6 while D_stall=1, F_stall=1, E_bubble=1 for one cycle → D_out and F_predPC unchanged; E_out.icode=1 with dstE=dstM=4'hF; next cycle D_out takes d_in.
- Mispredict: E_bubble=1 and D_bubble=1 for one cycle with d_in icode=4'h3, e_in icode=4'h6 → D_out.icode=1, E_out.icode=1, M_out takes m_in.
- Exception freeze: W_stall=1, M_bubble=1 for 3 cycles, w_in changing each cycle → W_out stays at its pre-stall value; M_out.stat=0 and icode=1.
- CC: set_cc=1 with cc_in=3'b011 → cc=3'b011 next edge; set_cc=0 with cc_in=3'b100 → cc remains 3'b011.
- Illegal combination: D_stall=1 and D_bubble=1 → D_out held, ctl_err=1, and ctl_err stays 1 until rst.
